button_reader: RTL and testbench

Debounced reader for a single active-low pushbutton, the input-side counterpart of the free-running LED blinker: where the blinker turns a counter into a slow pin waveform, this block turns a noisy, asynchronous pin into clean single-cycle events. It synchronises the pin and rejects bounce with a dwell counter. A hold timer classifies each press as short or long, and a wrapping press counter is kept. It sits directly behind a board button pin and feeds user logic on the 25 MHz board clock.

---
 rtl/button_reader.sv | 172 +++++++++++++++++
 tb/tb_button_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_reader.sv
// Debounced active-low pushbutton reader: 2-flop synchroniser, dwell-count
// debounce, short/long hold classification and a wrapping press counter.
//
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   btn_n          raw pin, low = pressed, asynchronous to clk
//   pressed        debounced level, high while the button is accepted down
//   press_pulse    1-cycle strobe on an accepted press
//   release_pulse  1-cycle strobe on an accepted release
//   short_press    1-cycle strobe with release_pulse when never long
//   long_press     1-cycle strobe when the hold timer expires while held
//   press_count    accepted presses, modulo 256
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    LONG_HELD,
    DEB_RELEASE
  } state_t;

  logic [1:0]    sync_q;
  logic          s;

  state_t        state_q, state_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          was_long_q, was_long_d;
  logic [7:0]    count_q, count_d;

  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          short_q, short_d;
  logic          long_q, long_d;

  // Reset value 1 means the pin reads as released until sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  assign s = ~sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      deb_q      <= '0;
      hold_q     <= '0;
      was_long_q <= 1'b0;
      count_q    <= '0;
      pressed_q  <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      was_long_q <= was_long_d;
      count_q    <= count_d;
      pressed_q  <= pressed_d;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_d      = deb_q;
    hold_d     = hold_q;
    was_long_d = was_long_q;
    count_d    = count_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = DEB_PRESS;
          deb_d   = DW'(1);
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          hold_d  = '0;
          count_d = count_q + 8'd1;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_d    = DEB_RELEASE;
          deb_d      = DW'(1);
          was_long_d = 1'b0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      LONG_HELD: begin
        if (!s) begin
          state_d    = DEB_RELEASE;
          deb_d      = DW'(1);
          was_long_d = 1'b1;
        end
      end
      DEB_RELEASE: begin
        // Bounce back keeps the hold count where it was.
        if (s) begin
          state_d = was_long_q ? LONG_HELD : HELD;
        end else if (deb_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          short_d   = ~was_long_q;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pressed_d = (state_d == HELD) ||
                (state_d == LONG_HELD) ||
                (state_d == DEB_RELEASE);
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader: directed scenarios plus random
// pin activity, checked against a run-length reference model.
module tb_button_reader;

  localparam int D  = 4;
  localparam int L  = 10;
  localparam int GL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_n = 1'b1;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  button_reader #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .short_press(short_press),
    .long_press(long_press),
    .press_count(press_count)
  );

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;

  // Reference model: synchroniser pipe, accepted level, run length of
  // samples disagreeing with it, hold cycles and long flag.
  bit m_s1, m_s2, m_acc, m_lng;
  bit m_pp, m_rp, m_sp, m_lp;
  int m_run, m_held, m_cnt;

  int n_press, n_rel, n_long;
  int t_press, t_rel, t_long;
  bit short_at_rel, any_pressed, any_low;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_s1 = 1; m_s2 = 1; m_acc = 0; m_lng = 0;
    m_pp = 0; m_rp = 0; m_sp = 0; m_lp = 0;
    m_run = 0; m_held = 0; m_cnt = 0;
  endfunction

  function automatic void m_edge(input bit b);
    bit s;
    s = !m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    m_pp = 0; m_rp = 0; m_sp = 0; m_lp = 0;
    if (!m_acc) begin
      if (s) begin
        m_run++;
        if (m_run == D) begin
          m_acc = 1; m_run = 0; m_held = 0; m_lng = 0;
          m_pp = 1; m_cnt = (m_cnt + 1) % 256;
        end
      end else begin
        m_run = 0;
      end
    end else if (!s) begin
      m_run++;
      if (m_run == D) begin
        m_acc = 0; m_run = 0; m_rp = 1; m_sp = !m_lng;
      end
    end else if (m_run > 0) begin
      m_run = 0;
    end else if (!m_lng) begin
      m_held++;
      if (m_held == L) begin
        m_lng = 1; m_lp = 1;
      end
    end
  endfunction

  task automatic step(input int n);
    logic [12:0] exp;
    repeat (n) begin
      @(posedge clk);
      m_edge(btn_n);
      cyc++;
      #1;
      exp = {m_acc, m_pp, m_rp, m_sp, m_lp, 8'(m_cnt)};
      chk($sformatf("outs@%0d", cyc),
          32'({pressed, press_pulse, release_pulse, short_press,
               long_press, press_count}), 32'(exp));
      if (press_pulse) begin n_press++; t_press = cyc; end
      if (release_pulse) begin
        n_rel++; t_rel = cyc; short_at_rel = short_press;
      end
      if (long_press) begin n_long++; t_long = cyc; end
      if (pressed) any_pressed = 1;
      else any_low = 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("reset outs",
        32'({pressed, press_pulse, release_pulse, short_press,
             long_press, press_count}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int e0, r0, np0, nr0, nl0;
    bit lvl;
    m_reset();
    #2;
    do_reset();

    // Idle
    btn_n = 1'b1;
    step(20);
    chk("idle count", 32'(press_count), 32'd0);
    chk("idle strobes", 32'(n_press + n_rel + n_long), 32'd0);

    // Long press
    btn_n = 1'b0; e0 = cyc + 1; nl0 = n_long;
    step(30);
    btn_n = 1'b1; r0 = cyc + 1;
    step(12);
    chk("t2 press lat", 32'(t_press), 32'(e0 + D + 1));
    chk("t2 count", 32'(press_count), 32'd1);
    chk("t2 long lat", 32'(t_long - t_press), 32'(L));
    chk("t2 long once", 32'(n_long - nl0), 32'd1);
    chk("t2 rel lat", 32'(t_rel), 32'(r0 + D + 1));
    chk("t2 short", 32'(short_at_rel), 32'd0);

    // Short press
    btn_n = 1'b0; e0 = cyc + 1; nl0 = n_long;
    step(8);
    btn_n = 1'b1; r0 = cyc + 1;
    step(12);
    chk("t3 press lat", 32'(t_press), 32'(e0 + D + 1));
    chk("t3 rel lat", 32'(t_rel), 32'(r0 + D + 1));
    chk("t3 short", 32'(short_at_rel), 32'd1);
    chk("t3 no long", 32'(n_long - nl0), 32'd0);

    // Press bounce shorter than the dwell
    np0 = n_press; nr0 = n_rel; nl0 = n_long; any_pressed = 0;
    btn_n = 1'b0; step(3);
    btn_n = 1'b1; step(1);
    btn_n = 1'b0; step(2);
    btn_n = 1'b1; step(5);
    chk("t4 no press", 32'(n_press - np0), 32'd0);
    chk("t4 no strobes", 32'(n_rel - nr0 + n_long - nl0), 32'd0);
    chk("t4 pressed", 32'(any_pressed), 32'd0);
    chk("t4 count", 32'(press_count), 32'd2);

    // Release bounce while held
    nr0 = n_rel; nl0 = n_long;
    btn_n = 1'b0;
    step(8);
    any_low = 0;
    btn_n = 1'b1; step(GL);
    btn_n = 1'b0; step(20);
    chk("t5 pressed", 32'(any_low), 32'd0);
    chk("t5 no rel", 32'(n_rel - nr0), 32'd0);
    chk("t5 long once", 32'(n_long - nl0), 32'd1);
    // Glitch cycles plus the edge that re-enters the held state.
    chk("t5 long delay", 32'(t_long - t_press), 32'(L + GL + 1));
    btn_n = 1'b1;
    step(12);

    // Counter wrap
    do_reset();
    np0 = n_press;
    for (int i = 0; i < 257; i++) begin
      btn_n = 1'b0; step(6);
      btn_n = 1'b1; step(6);
    end
    chk("wrap presses", 32'(n_press - np0), 32'd257);
    chk("wrap count", 32'(press_count), 32'd1);

    // Reset mid-press, released with the button still held
    btn_n = 1'b0;
    step(7);
    nr0 = n_rel; np0 = n_press;
    do_reset();
    step(12);
    chk("rst no rel", 32'(n_rel - nr0), 32'd0);
    chk("rst held press", 32'(n_press - np0), 32'd1);
    chk("rst held count", 32'(press_count), 32'd1);
    btn_n = 1'b1;
    step(10);

    // Random pin activity
    lvl = 1'b1;
    for (int i = 0; i < 80; i++) begin
      lvl = ~lvl;
      btn_n = lvl;
      step(int'($urandom_range(1, 18)));
    end
    btn_n = 1'b1;
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
